// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA layer mixer slice:
//   - game status encodings (RESTART/START/PLAY/DIE)
//   - snake codes at a pixel (none/head/body/wall)
//   - 3-bit layer code produced by the classifier stage
//   - color_const(): palette entries for any COLOR_W that is a multiple of 3
package vga_pkg;

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        SNK_NONE = 2'b00,
        SNK_HEAD = 2'b01,
        SNK_BODY = 2'b10,
        SNK_WALL = 2'b11
    } snake_e;

    // LAYER_BG must stay 0: a reset pipeline then decodes as plain background.
    typedef enum logic [2:0] {
        LAYER_BG      = 3'd0,
        LAYER_WALL    = 3'd1,
        LAYER_BODY    = 3'd2,
        LAYER_HEAD    = 3'd3,
        LAYER_BORDER  = 3'd4,
        LAYER_OVERLAY = 3'd5,
        LAYER_START   = 3'd6
    } layer_e;

    typedef enum logic [2:0] {
        COL_BLACK,
        COL_WHITE,
        COL_RED,
        COL_GREEN,
        COL_BLUE,
        COL_GRAY
    } color_e;

    // Widest colour the palette function can build.
    localparam int MAX_COLOR_W = 48;

    // Palette entry for a colour of color_w bits laid out as {R, G, B}.
    // Gray sets only the MSB of each channel.
    function automatic logic [MAX_COLOR_W-1:0] color_const(color_e col, int color_w);
        int                     ch_w;
        logic [MAX_COLOR_W-1:0] ones;
        logic [MAX_COLOR_W-1:0] msb;
        ch_w = color_w / 3;
        ones = (48'd1 << ch_w) - 48'd1;
        msb  = 48'd1 << (ch_w - 1);
        case (col)
            COL_WHITE: color_const = ones | (ones << ch_w) | (ones << (2 * ch_w));
            COL_RED:   color_const = ones << (2 * ch_w);
            COL_GREEN: color_const = ones << ch_w;
            COL_BLUE:  color_const = ones;
            COL_GRAY:  color_const = msb | (msb << ch_w) | (msb << (2 * ch_w));
            default:   color_const = '0;
        endcase
    endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// vga_layer_mixer_if
// Pixel bundle between the game/score/start-screen generators and the mixer.
//   master: generator side, drives per-pixel layer data, receives the result
//   slave : mixer side
// Signals: status, snake, egg, score_char, st_pixel, de, frame_start,
//          posx, posy (to mixer); data_out, de_out (from mixer).
interface vga_layer_mixer_if #(
    parameter int COLOR_W = 12,
    parameter int POS_W   = 10
);
    logic [1:0]         status;
    logic [1:0]         snake;
    logic               egg;
    logic               score_char;
    logic [COLOR_W-1:0] st_pixel;
    logic               de;
    logic               frame_start;
    logic [POS_W-1:0]   posx;
    logic [POS_W-1:0]   posy;
    logic [COLOR_W-1:0] data_out;
    logic               de_out;

    modport master (
        output status, snake, egg, score_char, st_pixel, de, frame_start, posx, posy,
        input  data_out, de_out
    );

    modport slave (
        input  status, snake, egg, score_char, st_pixel, de, frame_start, posx, posy,
        output data_out, de_out
    );
endinterface

// File: rtl/vga_blink_ctr.sv
// vga_blink_ctr
// Frame counter driving the snake blink on the DIE screen.
//   clk25, rst_n : pixel clock, async active-low reset
//   status       : game status (only DIE lets the counter run)
//   frame_start  : one-cycle pulse on the first pixel of a frame
//   blink_off    : 1 while the snake should be hidden
// Any cycle outside DIE clears the counter and blink_off. A frame_start that
// lands on the first DIE cycle is not counted, so counting starts on the
// next pulse.
module vga_blink_ctr
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [1:0] status,
    input  logic       frame_start,
    output logic       blink_off
);
    localparam int              CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_off_q, blink_off_d;
    logic             in_die_q, in_die_d;

    always_comb begin
        in_die_d    = (status == ST_DIE);
        cnt_d       = cnt_q;
        blink_off_d = blink_off_q;
        if (!in_die_d) begin
            cnt_d       = '0;
            blink_off_d = 1'b0;
        end else if (frame_start && in_die_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d       = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            blink_off_q <= 1'b0;
            in_die_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            blink_off_q <= blink_off_d;
            in_die_q    <= in_die_d;
        end
    end

    assign blink_off = blink_off_q;
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer
// Two-stage pixel compositor for the snake game's VGA path (clk25 domain).
//   clk25, rst_n : pixel clock, async active-low reset
//   bus (slave)  : per-pixel layer flags in, composited colour + de_out out
// Stage 1 classifies the pixel into a layer code and registers it with
// st_pixel and de; stage 2 maps the layer to a colour, blanks when de=0 and
// registers data_out/de_out. Latency is 2 cycles, one pixel per cycle.
// Optional feature: define VGA_MIXER_BLINK_EN to blink the snake on the DIE
// screen every BLINK_FRAMES frames; without it DIE renders like PLAY.
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int COLOR_W      = 12,
    parameter int POS_W        = 10,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BORDER_W     = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk25,
    input  logic              rst_n,
    vga_layer_mixer_if.slave  bus
);
    localparam logic [COLOR_W-1:0] C_BLACK = COLOR_W'(color_const(COL_BLACK, COLOR_W));
    localparam logic [COLOR_W-1:0] C_WHITE = COLOR_W'(color_const(COL_WHITE, COLOR_W));
    localparam logic [COLOR_W-1:0] C_RED   = COLOR_W'(color_const(COL_RED,   COLOR_W));
    localparam logic [COLOR_W-1:0] C_GREEN = COLOR_W'(color_const(COL_GREEN, COLOR_W));
    localparam logic [COLOR_W-1:0] C_BLUE  = COLOR_W'(color_const(COL_BLUE,  COLOR_W));
    localparam logic [COLOR_W-1:0] C_GRAY  = COLOR_W'(color_const(COL_GRAY,  COLOR_W));

    logic border_hit;
    logic blink_off;
    logic hide_snake;

    // ---------------- border detect ----------------
    generate
        if (BORDER_W > 0) begin : g_border
            localparam logic [POS_W-1:0] BW_LO = POS_W'(BORDER_W);
            localparam logic [POS_W-1:0] X_HI  = POS_W'(H_ACTIVE - BORDER_W);
            localparam logic [POS_W-1:0] Y_HI  = POS_W'(V_ACTIVE - BORDER_W);
            assign border_hit = (bus.posx < BW_LO) || (bus.posx >= X_HI) ||
                                (bus.posy < BW_LO) || (bus.posy >= Y_HI);
        end else begin : g_no_border
            logic unused_pos;
            assign unused_pos = ^{bus.posx, bus.posy};
            assign border_hit = 1'b0;
        end
    endgenerate

    // ---------------- blink control ----------------
`ifdef VGA_MIXER_BLINK_EN
    vga_blink_ctr #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_ctr (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .status      (bus.status),
        .frame_start (bus.frame_start),
        .blink_off   (blink_off)
    );
`else
    logic unused_frame_start;
    assign unused_frame_start = bus.frame_start;
    assign blink_off          = 1'b0;
`endif

    // blink_off can still be set on the first cycle after leaving DIE, so the
    // current pixel's status gates it.
    assign hide_snake = blink_off && (bus.status == ST_DIE);

    // ---------------- stage 1: classify ----------------
    layer_e             layer_q, layer_d;
    logic [COLOR_W-1:0] st_pixel_q, st_pixel_d;
    logic               de_q, de_d;

    always_comb begin
        layer_d    = LAYER_BG;
        st_pixel_d = bus.st_pixel;
        de_d       = bus.de;
        if (bus.status == ST_RESTART || bus.status == ST_START) begin
            layer_d = LAYER_START;
        end else if (bus.egg || bus.score_char) begin
            layer_d = LAYER_OVERLAY;
        end else if (border_hit) begin
            layer_d = LAYER_BORDER;
        end else begin
            case (bus.snake)
                SNK_HEAD: layer_d = hide_snake ? LAYER_BG : LAYER_HEAD;
                SNK_BODY: layer_d = hide_snake ? LAYER_BG : LAYER_BODY;
                SNK_WALL: layer_d = LAYER_WALL;
                default:  layer_d = LAYER_BG;
            endcase
        end
    end

    // ---------------- stage 2: colour map + blanking ----------------
    logic [COLOR_W-1:0] data_out_q, data_out_d;
    logic               de_out_q, de_out_d;

    always_comb begin
        data_out_d = '0;
        de_out_d   = de_q;
        if (de_q) begin
            case (layer_q)
                LAYER_OVERLAY: data_out_d = C_BLACK;
                LAYER_BORDER:  data_out_d = C_GRAY;
                LAYER_HEAD:    data_out_d = C_BLUE;
                LAYER_BODY:    data_out_d = C_GREEN;
                LAYER_WALL:    data_out_d = C_RED;
                LAYER_START:   data_out_d = st_pixel_q;
                default:       data_out_d = C_WHITE;
            endcase
        end
    end

    // NOTE: the async reset clears every pipeline register so outputs drop to
    // 0 the moment rst_n falls, not at the next clock edge.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            layer_q    <= LAYER_BG;
            st_pixel_q <= '0;
            de_q       <= 1'b0;
            data_out_q <= '0;
            de_out_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, which is what makes this a pipeline.
            layer_q    <= layer_d;
            st_pixel_q <= st_pixel_d;
            de_q       <= de_d;
            data_out_q <= data_out_d;
            de_out_q   <= de_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.de_out   = de_out_q;
endmodule
